// File: rtl/stereo_pkg.sv
// ============================================================================
// Module      : stereo_pkg
// Description : Shared types and decimated image geometry for the stereo path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stereo_pkg;

    localparam int IMG_W_DEC = 120;
    localparam int IMG_H_DEC = 240;

    typedef struct packed {
        logic [12:0] disp_conf;
        logic [7:0]  conf;
    } dc_word_t;

    typedef enum logic {
        FREE = 1'b0,
        FULL = 1'b1
    } bank_state_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

endpackage

`default_nettype wire

// File: rtl/col_addr_gen.sv
// ============================================================================
// Module      : col_addr_gen
// Description : Column-major read address walker (row/col/raddr counters).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module col_addr_gen #(
    parameter int img_w = 120,
    parameter int img_h = 240,
    parameter int aw    = $clog2(img_w * img_h)
) (
    input  logic          clk50,
    input  logic          reset,
    input  logic          start,
    input  logic          step,
    output logic [aw-1:0] raddr,
    output logic          sol,
    output logic          last
);

    localparam int c_rw = ($clog2(img_h) > 0) ? $clog2(img_h) : 1;
    localparam int c_cw = ($clog2(img_w) > 0) ? $clog2(img_w) : 1;
    localparam logic [c_rw-1:0] c_row_last = c_rw'(img_h - 1);
    localparam logic [c_cw-1:0] c_col_last = c_cw'(img_w - 1);
    localparam logic [aw-1:0]   c_row_step = aw'(img_w);

    logic [c_rw-1:0] r_row;
    logic [c_cw-1:0] r_col;
    logic [aw-1:0]   r_raddr;

    always_ff @(posedge clk50) begin
        if (!reset || start) begin
            r_row   <= '0;
            r_col   <= '0;
            r_raddr <= '0;
        end else if (step) begin
            if (r_row < c_row_last) begin
                r_row   <= r_row + 1'b1;
                r_raddr <= r_raddr + c_row_step;
            end else begin
                // next column starts at its own index in row 0
                r_row   <= '0;
                r_col   <= r_col + 1'b1;
                r_raddr <= aw'(r_col) + aw'(1);
            end
        end
    end

    assign raddr = r_raddr;
    assign sol   = (r_row == '0);
    assign last  = (r_row == c_row_last) && (r_col == c_col_last);

endmodule

`default_nettype wire

// File: rtl/transpose_bank_ctrl.sv
// ============================================================================
// Module      : transpose_bank_ctrl
// Description : Ping-pong row-major write / column-major read transpose
//               controller. Optional TRANSPOSE_OVF_CHECK_EN adds ovf_err.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module transpose_bank_ctrl
    import stereo_pkg::*;
#(
    parameter int img_w  = IMG_W_DEC,
    parameter int img_h  = IMG_H_DEC,
    parameter int data_w = 21,
    parameter int rd_lat = 2
) (
    input  logic                             clk50,
    input  logic                             reset,
    input  logic [data_w-1:0]                in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             bram_we,
    output logic                             bram_wbank,
    output logic [$clog2(img_w*img_h)-1:0]   bram_waddr,
    output logic [data_w-1:0]                bram_wdata,
    output logic                             bram_re,
    output logic                             bram_rbank,
    output logic [$clog2(img_w*img_h)-1:0]   bram_raddr,
    input  logic [data_w-1:0]                bram_rdata,
    output logic [data_w-1:0]                out_data,
    output logic                             out_valid,
    output logic                             out_sol,
    output logic                             frame_done
`ifdef TRANSPOSE_OVF_CHECK_EN
    ,
    output logic                             ovf_err
`endif
);

    localparam int c_aw = $clog2(img_w * img_h);
    localparam int c_lw = (rd_lat > 1) ? $clog2(rd_lat) : 1;
    localparam logic [c_aw-1:0] c_last_waddr = c_aw'(img_w * img_h - 1);
    localparam logic [c_lw-1:0] c_drain_last = c_lw'(rd_lat - 1);

    bank_state_e     r_bank [2];
    logic            r_wbank;
    logic            r_rbank;
    logic [c_aw-1:0] r_waddr;
    rd_state_e       r_state;
    rd_state_e       w_state_nxt;
    logic [c_lw-1:0] r_drain_cnt;
    logic [rd_lat-1:0] r_re_pipe;
    logic [rd_lat-1:0] r_sol_pipe;
    logic            r_frame_done;
    logic            w_wr;
    logic            w_wr_last;
    logic            w_start;
    logic            w_step;
    logic            w_sol;
    logic            w_last;
    logic            w_drain_done;
    logic            w_re;

    col_addr_gen #(
        .img_w (img_w),
        .img_h (img_h),
        .aw    (c_aw)
    ) u_col_addr_gen (
        .clk50 (clk50),
        .reset (reset),
        .start (w_start),
        .step  (w_step),
        .raddr (bram_raddr),
        .sol   (w_sol),
        .last  (w_last)
    );

    assign in_ready  = (r_bank[r_wbank] == FREE);
    assign w_wr      = in_valid & in_ready;
    assign w_wr_last = w_wr && (r_waddr == c_last_waddr);

    always_ff @(posedge clk50) begin
        if (!reset) begin
            r_waddr <= '0;
            r_wbank <= 1'b0;
        end else if (w_wr) begin
            if (w_wr_last) begin
                r_waddr <= '0;
                r_wbank <= ~r_wbank;
            end else begin
                r_waddr <= r_waddr + 1'b1;
            end
        end
    end

    // Writer and reader never own the same bank, so both updates may land together.
    always_ff @(posedge clk50) begin
        for (int b = 0; b < 2; b++) begin
            if (!reset) begin
                r_bank[b] <= FREE;
            end else if (w_wr_last && (r_wbank == 1'(b))) begin
                r_bank[b] <= FULL;
            end else if (w_drain_done && (r_rbank == 1'(b))) begin
                r_bank[b] <= FREE;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_step       = 1'b0;
        w_re         = 1'b0;
        w_drain_done = 1'b0;
        case (r_state)
            IDLE: begin
                w_start = 1'b1;
                if (r_bank[r_rbank] == FULL) begin
                    w_state_nxt = READ;
                end
            end
            READ: begin
                w_re   = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drain_cnt == c_drain_last) begin
                    w_drain_done = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_rbank      <= 1'b0;
            r_drain_cnt  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_drain_done;
            if (w_drain_done) begin
                r_rbank <= ~r_rbank;
            end
            if (r_state == DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

    // Qualifiers travel alongside the BRAM read latency.
    always_ff @(posedge clk50) begin
        if (!reset) begin
            r_re_pipe  <= '0;
            r_sol_pipe <= '0;
        end else begin
            r_re_pipe[0]  <= w_re;
            r_sol_pipe[0] <= w_re & w_sol;
            for (int i = 1; i < rd_lat; i++) begin
                r_re_pipe[i]  <= r_re_pipe[i-1];
                r_sol_pipe[i] <= r_sol_pipe[i-1];
            end
        end
    end

    assign bram_we    = w_wr;
    assign bram_wbank = r_wbank;
    assign bram_waddr = r_waddr;
    assign bram_wdata = in_data;
    assign bram_re    = w_re;
    assign bram_rbank = r_rbank;
    assign out_data   = bram_rdata;
    assign out_valid  = r_re_pipe[rd_lat-1];
    assign out_sol    = r_sol_pipe[rd_lat-1];
    assign frame_done = r_frame_done;

`ifdef TRANSPOSE_OVF_CHECK_EN
    logic r_ovf_err;

    always_ff @(posedge clk50) begin
        if (!reset) begin
            r_ovf_err <= 1'b0;
        end else if (in_valid && !in_ready) begin
            r_ovf_err <= 1'b1;
        end
    end

    always_ff @(posedge clk50) begin
        if (reset && in_valid && !in_ready) begin
            $error("transpose_bank_ctrl: word dropped, both banks full");
        end
    end

    assign ovf_err = r_ovf_err;
`endif

endmodule

`default_nettype wire

// File: tb/tb_transpose_bank_ctrl.sv
// ============================================================================
// Module      : tb_transpose_bank_ctrl
// Description : Randomized scoreboard bench for transpose_bank_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_transpose_bank_ctrl;

    localparam int W  = 12;
    localparam int H  = 8;
    localparam int N  = W * H;
    localparam int RD = 2;
    localparam int DW = 21;
    localparam int AW = $clog2(N);

    typedef struct packed {
        logic [DW-1:0] d;
        logic          sol;
    } exp_t;

    logic          clk50 = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          bram_we;
    logic          bram_wbank;
    logic [AW-1:0] bram_waddr;
    logic [DW-1:0] bram_wdata;
    logic          bram_re;
    logic          bram_rbank;
    logic [AW-1:0] bram_raddr;
    logic [DW-1:0] bram_rdata;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_sol;
    logic          frame_done;

    always #10 clk50 = ~clk50;

    transpose_bank_ctrl #(
        .img_w  (W),
        .img_h  (H),
        .data_w (DW),
        .rd_lat (RD)
    ) dut (
        .clk50      (clk50),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bram_we    (bram_we),
        .bram_wbank (bram_wbank),
        .bram_waddr (bram_waddr),
        .bram_wdata (bram_wdata),
        .bram_re    (bram_re),
        .bram_rbank (bram_rbank),
        .bram_raddr (bram_raddr),
        .bram_rdata (bram_rdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_sol    (out_sol),
        .frame_done (frame_done)
    );

    // Two-bank BRAM with RD-cycle read latency
    logic [DW-1:0] mem [2][N];
    logic [DW-1:0] rd_pipe [RD];

    always @(posedge clk50) begin
        if (bram_we) mem[bram_wbank][bram_waddr] <= bram_wdata;
        rd_pipe[0] <= mem[bram_rbank][bram_raddr];
        for (int i = 1; i < RD; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bram_rdata = rd_pipe[RD-1];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect a frame row-major, queue it transposed
    logic [DW-1:0] frame_buf[$];
    exp_t          exp_q[$];
    int            frames_sent = 0;

    task automatic accept(input logic [DW-1:0] d);
        frame_buf.push_back(d);
        if (frame_buf.size() == N) begin
            for (int c = 0; c < W; c++)
                for (int r = 0; r < H; r++)
                    exp_q.push_back('{d: frame_buf[r*W + c], sol: (r == 0)});
            frame_buf.delete();
            frames_sent++;
        end
    endtask

    // Monitor state
    bit mon_en      = 1'b0;
    int wr_frames   = 0;
    int wcount      = 0;
    int frames_done = 0;
    int emitted     = 0;
    bit prev_ov     = 1'b0;
    bit re_hist [RD];

    always @(negedge clk50) begin
        if (mon_en) begin
            if (frame_done) begin
                frames_done++;
                chk("frame_done_after_last", {31'd0, prev_ov}, 32'd1);
                chk("frame_word_count", emitted, N);
                emitted = 0;
            end
            chk("in_ready", {31'd0, in_ready}, {31'd0, (wr_frames - frames_done) < 2});
            if (bram_we) begin
                chk("waddr", bram_waddr, wcount);
                chk("wbank", {31'd0, bram_wbank}, wr_frames % 2);
                chk("wdata", bram_wdata, in_data);
                wcount++;
                if (wcount == N) begin
                    wcount = 0;
                    wr_frames++;
                end
            end
            if (bram_re) chk("rbank", {31'd0, bram_rbank}, frames_done % 2);
            chk("rd_latency", {31'd0, out_valid}, {31'd0, re_hist[RD-1]});
            for (int i = RD-1; i > 0; i--) re_hist[i] = re_hist[i-1];
            re_hist[0] = bram_re;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL out_unexpected actual=%0h required=no_output t=%0t", out_data, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.d);
                    chk("out_sol", {31'd0, out_sol}, {31'd0, e.sol});
                end
                emitted++;
            end
            prev_ov = out_valid;
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        @(posedge clk50); #1;
        in_valid = 1'b0;
        reset    = 1'b0;
        @(posedge clk50);
        @(negedge clk50);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_bram_we", {31'd0, bram_we}, 32'd0);
        chk("rst_bram_re", {31'd0, bram_re}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_sol", {31'd0, out_sol}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_addrs", {bram_waddr, bram_raddr}, 32'd0);
        chk("rst_banks", {30'd0, bram_wbank, bram_rbank}, 32'd0);
        @(posedge clk50); #1;
        reset = 1'b1;
        frame_buf.delete();
        exp_q.delete();
        frames_sent = 0;
        wr_frames   = 0;
        wcount      = 0;
        frames_done = 0;
        emitted     = 0;
        prev_ov     = 1'b0;
        for (int i = 0; i < RD; i++) re_hist[i] = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic drive_words(input int count, input int prob, input bit idx_data);
        int sent = 0;
        int cyc  = 0;
        bit have = 1'b0;
        logic [DW-1:0] d = '0;
        while (sent < count && cyc < 20*count + 200) begin
            @(posedge clk50); #1;
            cyc++;
            if (!have) begin
                d = idx_data ? DW'(frame_buf.size()) : DW'($urandom);
                have = 1'b1;
            end
            if ($urandom_range(99) < prob) begin
                in_valid = 1'b1;
                in_data  = d;
                if (in_ready) begin
                    accept(d);
                    have = 1'b0;
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk50); #1;
        in_valid = 1'b0;
        chk("drive_timeout", sent, count);
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while ((exp_q.size() != 0 || frames_done != frames_sent) && cyc < 8*N + 100) begin
            @(negedge clk50);
            cyc++;
        end
        repeat (3) @(negedge clk50);
        chk("frames_done", frames_done, frames_sent);
        chk("exp_left", exp_q.size(), 0);
    endtask

    initial begin
        do_reset();
        // single index-ramp frame
        drive_words(N, 100, 1'b1);
        wait_drain();
        // three back-to-back frames
        drive_words(3*N, 100, 1'b1);
        wait_drain();
        // random gaps and data
        drive_words(4*N, 70, 1'b0);
        wait_drain();
        // reset halfway through a read, then a clean frame into bank 0
        drive_words(N, 100, 1'b0);
        begin
            int cyc = 0;
            while (emitted < N/2 && cyc < 4*N) begin
                @(negedge clk50);
                cyc++;
            end
            chk("midread_reached", {31'd0, emitted >= N/2}, 32'd1);
        end
        do_reset();
        drive_words(N, 100, 1'b1);
        wait_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/transpose_bank_ctrl.md
# transpose_bank_ctrl

Ping-pong transpose controller between the horizontal and vertical `filter_and_pad_bank` passes. It accepts the horizontal pass's row-major disparity/confidence stream and writes it into one of two external BRAM banks. It then reads the full bank back column-major, so the second filter pass (`line_len` = image height) sees columns as lines. The two banks alternate so that writing frame N+1 overlaps reading frame N.

## Interface
Parameters:
- `img_w`, 120, pixels per row of the incoming stream
- `img_h`, 240, rows per frame; equals the vertical pass's `line_len`
- `data_w`, 21, word width ({disp_conf[12:0], conf[7:0]})
- `rd_lat`, 2, BRAM read latency in cycles

Ports:
- `clk50`  in  1  clock
- `reset`  in  1  synchronous, active-low
- `in_data`  in  data_w  word from horizontal pass
- `in_valid`  in  1  word qualifier
- `in_ready`  out  1  high when a free bank is available for writing
- `bram_we`  out  1  write strobe
- `bram_wbank`  out  1  bank selected for the write
- `bram_waddr`  out  $clog2(img_w*img_h)  row-major write address
- `bram_wdata`  out  data_w  equals `in_data`
- `bram_re`  out  1  read strobe
- `bram_rbank`  out  1  bank selected for the read
- `bram_raddr`  out  $clog2(img_w*img_h)  column-major read address
- `bram_rdata`  in  data_w  valid `rd_lat` cycles after `bram_re`
- `out_data`  out  data_w  word to the vertical pass
- `out_valid`  out  1  output qualifier
- `out_sol`  out  1  marks the first word of each column
- `frame_done`  out  1  one-cycle pulse after the last word of a bank is emitted

## Operation
- Each bank carries one status bit: `FREE` or `FULL`. Both banks are `FREE` at reset.
- Write side:
  - Words are accepted only when `in_valid & in_ready`.
  - `in_ready` is high when the bank under `wbank` is `FREE`.
  - Each accepted word produces `bram_we=1`, `bram_waddr=waddr`, then `waddr++`.
  - On the last word (`waddr == img_w*img_h-1`): mark the bank `FULL`, clear `waddr` to 0, toggle `wbank`.
- Read FSM states are `IDLE`, `READ` and `DRAIN`.
  - `IDLE`: when the bank under `rbank` is `FULL`, go to `READ` with `row=0`, `col=0` and `raddr=0`.
  - `READ`: assert `bram_re` every cycle with `raddr`.
    - While `row < img_h-1`: `row++`, `raddr += img_w`.
    - Otherwise: `row=0`, `col++`, `raddr = col+1`.
    - After the read issued at `row=img_h-1` and `col=img_w-1`, go to `DRAIN`.
  - `DRAIN`: wait `rd_lat` cycles. Then mark the bank `FREE`, toggle `rbank`, pulse `frame_done`, and return to `IDLE`.
- Output: `out_valid` is `bram_re` delayed by `rd_lat`, and `out_data = bram_rdata`. `out_sol` is (`row==0` at issue) delayed by `rd_lat`.
- The vertical pass has no backpressure, so reads run at one word per cycle with no stalls.

## Timing
- Reset values: `in_ready=1`, `bram_we=0`, `bram_re=0`, `out_valid=0`, `out_sol=0`, `frame_done=0`. All addresses, `wbank` and `rbank` are 0, and the FSM is in `IDLE`.
- Write path is combinational: `bram_we = in_valid & in_ready` in the same cycle.
- First `bram_re` occurs 1 cycle after the bank becomes `FULL`. The first `out_valid` follows `rd_lat` cycles later.
- A frame read takes `img_w*img_h` cycles of `READ` plus `rd_lat` cycles of `DRAIN`.
- Simultaneous events:
  - The writer may mark one bank `FULL` in the same cycle the reader frees the other. Both updates apply.
  - The writer may never target the bank being read, because that bank stays `FULL` until `DRAIN` ends.
- When both banks are `FULL`, `in_ready` is 0 until `frame_done`. `in_ready` returns to 1 in the same cycle `frame_done` pulses.
- Reset mid-frame discards all state. Partially written or partially read banks become `FREE`, and the pipelined `out_valid` is cleared.

## Configuration
- `TRANSPOSE_OVF_CHECK_EN` defined:
  - Adds output `ovf_err` (1 bit), reset to 0.
  - Sets sticky on any cycle with `in_valid & ~in_ready`; only `reset` clears it.
  - Simulation also issues `$error` on that event.
- Undefined: the port and logic are absent, and dropped words are silent.

## Structure
- Shared package `stereo_pkg`:
  - `IMG_W_DEC=120`, `IMG_H_DEC=240`
  - `dc_word_t` (packed `disp_conf[12:0]`, `conf[7:0]`)
  - `bank_state_e` (`FREE`, `FULL`)
  - `rd_state_e` (`IDLE`, `READ`, `DRAIN`)
- One sub-module, `col_addr_gen`: the row/col/raddr counters with `start`, `step` and `last` outputs. Everything else stays in the top.

## Test plan
- Write 120×240 words with `data = index`, then let the read run. `out_data` sequence must be 0, 120, 240, …, 28680, 1, 121, …; `out_sol` fires 120 times, every 240 words; `frame_done` pulses once.
- Stream 3 frames back-to-back with continuous `in_valid`. Frame 2 writes overlap frame 1 reads; `in_ready` drops only while both banks are `FULL`; all 3 frames are emitted in order with no word loss.
- Hold `in_valid` through a both-banks-full window with `TRANSPOSE_OVF_CHECK_EN` defined. `ovf_err` rises on the first dropped-word cycle and stays 1.
- Time `frame_done` to coincide with the last write of the next frame. The bank freed by the read accepts the next word in the following cycle, and `wbank`/`rbank` stay consistent.
- Assert `reset=0` halfway through a read. All outputs go to reset values the next cycle, and a new full frame then reads back correctly from bank 0.
- Sweep `rd_lat` = 1 and 3. `out_valid` trails `bram_re` by exactly `rd_lat` cycles, and `frame_done` follows the last `out_valid` by 1 cycle.
